// File: rtl/booth4_iter_mult_ctrl_if.sv
// Operand, product and decoder-side bus of the iterative Radix-4 Booth multiplier.
// The slave modport is the sequencer's view; the master modport belongs to
// whatever feeds operands, takes products and hosts the partial-product decoder.
interface booth4_iter_mult_ctrl_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_a;
    logic signed [15:0] in_b;

    logic [2:0]         dec_code;
    logic signed [15:0] dec_a;
    logic [15:0]        dec_inv_a;
    logic signed [16:0] dec_pp;

    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_p;

    modport master (
        output in_valid, in_a, in_b, out_ready, dec_pp,
        input  in_ready, out_valid, out_p, dec_code, dec_a, dec_inv_a
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, dec_pp,
        output in_ready, out_valid, out_p, dec_code, dec_a, dec_inv_a
    );
endinterface

// File: rtl/booth4_iter_mult_ctrl.sv
// Iterative 16x16 signed multiplier built around one shared Radix-4 Booth
// partial-product decoder. One Booth group is issued per cycle; the decoder
// returns a 17-bit partial product that is corrected for its one's-complement
// negation and accumulated at weight 4^i into a 32-bit product.
module booth4_iter_mult_ctrl #(
    parameter int DATA_W = 16,
    parameter int N_STEP = DATA_W / 2
) (
    input  logic                    clk,
    input  logic                    rst,
    booth4_iter_mult_ctrl_if.slave  bus,
    output logic                    busy
);

    if (DATA_W != 16 || N_STEP != DATA_W / 2) begin : g_bad_width
        $error("booth4_iter_mult_ctrl: only DATA_W=16 with N_STEP=DATA_W/2 is supported");
    end

    localparam logic [2:0] LAST_STEP = 3'(N_STEP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic signed [DATA_W-1:0]  a_r;
    logic signed [DATA_W-1:0]  b_r;
    logic [2:0]                step;
    logic signed [31:0]        acc;
    logic                      accept;
    logic [DATA_W:0]           b_ext;
    logic [4:0]                grp_lsb;
    logic [2:0]                code;
    logic signed [31:0]        term;

    // The decoder negates with a one's complement: -2A arrives as -2A-2 and
    // -A as -A-1, so those codes need +2 / +1 added back before weighting.
    function automatic logic [1:0] booth_corr(input logic [2:0] c);
        case (c)
            3'b100:         return 2'd2;
            3'b101, 3'b110: return 2'd1;
            default:        return 2'd0;
        endcase
    endfunction

    // Sign-extend the partial product, apply the negation correction and
    // place it at weight 4^stp. Everything wraps mod 2^32; |A*B| <= 2^30 so
    // the final sum is exact.
    function automatic logic signed [31:0] weigh_pp(
        input logic signed [16:0] pp,
        input logic [1:0]         corr,
        input logic [2:0]         stp
    );
        logic signed [31:0] v;
        v = {{15{pp[16]}}, pp} + {30'd0, corr};
        return v << {stp, 1'b0};
    endfunction

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (step == LAST_STEP) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Booth group i is {B[2i+1], B[2i], B[2i-1]} with B[-1] = 0; the decoder
    // sees 000 (zero product) whenever no step is being issued.
    assign b_ext   = {b_r, 1'b0};
    assign grp_lsb = {1'b0, step, 1'b0};

    // Booth code issued to the decoder for the current step.
    always_comb begin
        code = 3'b000;
        if (state == S_RUN) begin
            code = b_ext[grp_lsb +: 3];
        end
    end

    assign term = weigh_pp(bus.dec_pp, booth_corr(code), step);

    // Operand latch, step counter and product accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            step <= '0;
            acc  <= '0;
        end else if (accept) begin
            a_r  <= bus.in_a;
            b_r  <= bus.in_b;
            step <= '0;
            acc  <= '0;
        end else if (state == S_RUN) begin
            acc  <= acc + term;
            step <= step + 3'd1;
        end
    end

    assign bus.dec_code  = code;
    assign bus.dec_a     = a_r;
    assign bus.dec_inv_a = ~a_r;
    assign bus.out_p     = acc;

endmodule
